// File: rtl/lookup_cfg_writer.sv
// lookup_cfg_writer
// Turns table-configuration messages from a 256-bit AXI-Stream slave into
// single-cycle write strobes on the CAM entry port and the action-RAM port
// of one match-action stage. Messages addressed to another stage, or with an
// unknown type, are consumed and discarded.
//
// Handshake: a beat transfers on a clk edge where s_axis_tvalid && s_axis_tready.
// s_axis_tready is low only in the WRITE cycle and during reset.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   s_axis_tdata/tvalid/tlast     config stream in
//   s_axis_tready                 stream ready out
//   lookup_din, lookup_din_mask   CAM entry data / mask (1024 bits each)
//   lookup_din_addr, lookup_din_en  CAM index and 1-cycle write strobe
//   action_data_in                action word (ACT_LEN*25 bits)
//   action_addr, action_en        action-RAM index and 1-cycle write strobe
//   cfg_err                       1-cycle pulse on a malformed message
//   cfg_wr_cnt                    completed writes, wraps
module lookup_cfg_writer #(
    parameter logic [3:0] STAGE               = 4'd0,
    parameter int         ACT_LEN             = 25,
    parameter int         C_S_AXIS_DATA_WIDTH = 256
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                           s_axis_tvalid,
    input  logic                           s_axis_tlast,
    output logic                           s_axis_tready,
    output logic [1023:0]                  lookup_din,
    output logic [1023:0]                  lookup_din_mask,
    output logic [3:0]                     lookup_din_addr,
    output logic                           lookup_din_en,
    output logic [ACT_LEN*25-1:0]          action_data_in,
    output logic [3:0]                     action_addr,
    output logic                           action_en,
    output logic                           cfg_err,
    output logic [15:0]                    cfg_wr_cnt
);

    localparam int ACT_W = ACT_LEN * 25;
    localparam logic [3:0] TYPE_CAM = 4'h1;
    localparam logic [3:0] TYPE_ACT = 4'h2;

    typedef enum logic [2:0] {IDLE, CAM_PAY, ACT_PAY, DROP, WRITE} state_t;

    state_t     state;
    logic [2:0] cnt;
    logic [3:0] addr_q;

    // Shadow slots for all but the final payload beat. The final beat goes
    // straight into the output registers together with these slots, so the
    // visible outputs never show a partially assembled (or aborted) message.
    logic [C_S_AXIS_DATA_WIDTH-1:0] cam_buf [7];
    logic [C_S_AXIS_DATA_WIDTH-1:0] act_buf [2];

    logic       accept;
    logic [3:0] hdr_type;
    logic       hdr_match;

    assign s_axis_tready = (state != WRITE) && !rst;
    assign accept        = s_axis_tvalid && s_axis_tready;
    assign hdr_type      = s_axis_tdata[7:4];
    assign hdr_match     = (s_axis_tdata[11:8] == STAGE) &&
                           ((hdr_type == TYPE_CAM) || (hdr_type == TYPE_ACT));

    // Assembly slots need no reset: every slot is rewritten before it is used.
    always_ff @(posedge clk) begin
        if (accept && (state == CAM_PAY) && (cnt != 3'd7)) begin
            cam_buf[cnt] <= s_axis_tdata;
        end
        if (accept && (state == ACT_PAY) && (cnt != 3'd2)) begin
            act_buf[cnt[0]] <= s_axis_tdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            cnt             <= 3'd0;
            addr_q          <= 4'd0;
            lookup_din      <= '0;
            lookup_din_mask <= '0;
            lookup_din_addr <= 4'd0;
            lookup_din_en   <= 1'b0;
            action_data_in  <= '0;
            action_addr     <= 4'd0;
            action_en       <= 1'b0;
            cfg_err         <= 1'b0;
            cfg_wr_cnt      <= 16'd0;
        end else begin
            lookup_din_en <= 1'b0;
            action_en     <= 1'b0;
            cfg_err       <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        cnt    <= 3'd0;
                        addr_q <= s_axis_tdata[3:0];
                        if (hdr_match) begin
                            // A matching header must carry a payload.
                            if (s_axis_tlast) begin
                                cfg_err <= 1'b1;
                            end else if (hdr_type == TYPE_CAM) begin
                                state <= CAM_PAY;
                            end else begin
                                state <= ACT_PAY;
                            end
                        end else if (!s_axis_tlast) begin
                            state <= DROP;
                        end
                    end
                end
                CAM_PAY: begin
                    if (accept) begin
                        cnt <= cnt + 3'd1;
                        if (cnt == 3'd7) begin
                            if (s_axis_tlast) begin
                                lookup_din      <= {cam_buf[3], cam_buf[2], cam_buf[1], cam_buf[0]};
                                lookup_din_mask <= {s_axis_tdata, cam_buf[6], cam_buf[5], cam_buf[4]};
                                lookup_din_addr <= addr_q;
                                lookup_din_en   <= 1'b1;
                                state           <= WRITE;
                            end else begin
                                cfg_err <= 1'b1;
                                state   <= DROP;
                            end
                        end else if (s_axis_tlast) begin
                            cfg_err <= 1'b1;
                            state   <= IDLE;
                        end
                    end
                end
                ACT_PAY: begin
                    if (accept) begin
                        cnt <= cnt + 3'd1;
                        if (cnt == 3'd2) begin
                            if (s_axis_tlast) begin
                                // 768 assembled bits; the top bits beyond the action word are dropped.
                                action_data_in <= ACT_W'({s_axis_tdata, act_buf[1], act_buf[0]});
                                action_addr    <= addr_q;
                                action_en      <= 1'b1;
                                state          <= WRITE;
                            end else begin
                                cfg_err <= 1'b1;
                                state   <= DROP;
                            end
                        end else if (s_axis_tlast) begin
                            cfg_err <= 1'b1;
                            state   <= IDLE;
                        end
                    end
                end
                DROP: begin
                    if (accept && s_axis_tlast) begin
                        state <= IDLE;
                    end
                end
                WRITE: begin
                    cfg_wr_cnt <= cfg_wr_cnt + 16'd1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lookup_cfg_writer.sv
module tb_lookup_cfg_writer;

    logic           clk;
    logic           rst;
    logic [255:0]   s_axis_tdata;
    logic           s_axis_tvalid;
    logic           s_axis_tlast;
    logic           s_axis_tready;
    logic [1023:0]  lookup_din;
    logic [1023:0]  lookup_din_mask;
    logic [3:0]     lookup_din_addr;
    logic           lookup_din_en;
    logic [624:0]   action_data_in;
    logic [3:0]     action_addr;
    logic           action_en;
    logic           cfg_err;
    logic [15:0]    cfg_wr_cnt;

    lookup_cfg_writer #(.STAGE(4'd0), .ACT_LEN(25), .C_S_AXIS_DATA_WIDTH(256)) dut (
        .clk             (clk),
        .rst             (rst),
        .s_axis_tdata    (s_axis_tdata),
        .s_axis_tvalid   (s_axis_tvalid),
        .s_axis_tlast    (s_axis_tlast),
        .s_axis_tready   (s_axis_tready),
        .lookup_din      (lookup_din),
        .lookup_din_mask (lookup_din_mask),
        .lookup_din_addr (lookup_din_addr),
        .lookup_din_en   (lookup_din_en),
        .action_data_in  (action_data_in),
        .action_addr     (action_addr),
        .action_en       (action_en),
        .cfg_err         (cfg_err),
        .cfg_wr_cnt      (cfg_wr_cnt)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int err_pulses = 0;
    int stalls = 0;
    int bubble_bad = 0;

    // Expected strobes: {is_cam, addr}
    logic [4:0] exp_q[$];

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_wide(input string tag, input logic [1023:0] got, input logic [1023:0] exp);
        for (int c = 0; c < 4; c++)
            check($sformatf("%s[%0d]", tag, c), got[c*256 +: 256], exp[c*256 +: 256]);
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (lookup_din_en || action_en) begin
            if (s_axis_tready) bubble_bad++;
            if (exp_q.size() == 0) begin
                check("unexpected_strobe", 256'(lookup_din_en ? lookup_din_addr : action_addr), 256'h1ff);
            end else begin
                check("strobe", 256'({lookup_din_en, lookup_din_en ? lookup_din_addr : action_addr}),
                      256'(exp_q.pop_front()));
            end
            if (lookup_din_en && action_en) check("both_strobes", 256'd1, 256'd0);
        end
        if (cfg_err) err_pulses++;
    end

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [255:0] d, input logic last, input int gap);
        int n;
        s_axis_tvalid = 1'b0;
        for (int i = 0; i < gap; i++) begin @(posedge clk); #1; end
        s_axis_tdata  = d;
        s_axis_tlast  = last;
        s_axis_tvalid = 1'b1;
        @(negedge clk);
        if (!s_axis_tready) stalls++;
        n = 0;
        while (!s_axis_tready && n < 20) begin @(negedge clk); n++; end
        if (!s_axis_tready) check("tready_timeout", 256'd0, 256'd1);
        @(posedge clk); #1;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic send_cam(input logic [11:0] hdr, input logic [1023:0] din,
                            input logic [1023:0] mask, input int max_gap);
        send_beat({244'd0, hdr}, 1'b0, 0);
        for (int k = 0; k < 8; k++)
            send_beat(k < 4 ? din[k*256 +: 256] : mask[(k-4)*256 +: 256], k == 7,
                      $urandom_range(0, max_gap));
    endtask

    task automatic send_act(input logic [11:0] hdr, input logic [767:0] pay);
        send_beat({244'd0, hdr}, 1'b0, 0);
        for (int k = 0; k < 3; k++) send_beat(pay[k*256 +: 256], k == 2, 0);
    endtask

    // ---------------- stimulus ----------------
    logic [1023:0] din_a, mask_f, din_g, mask_g;
    logic [767:0]  act1, act2;
    logic [255:0]  beat_tmp;

    initial begin
        s_axis_tdata = '0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("tready_in_reset", 256'(s_axis_tready), 256'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle(1);

        // reset state
        check_wide("rst_din", lookup_din, '0);
        check_wide("rst_mask", lookup_din_mask, '0);
        check("rst_act", 256'(action_data_in[255:0]), 256'd0);
        check("rst_addrs", 256'({lookup_din_addr, action_addr}), 256'd0);
        check("rst_strobes", 256'({lookup_din_en, action_en, cfg_err}), 256'd0);
        check("rst_wr_cnt", 256'(cfg_wr_cnt), 256'd0);
        check("tready_idle", 256'(s_axis_tready), 256'd1);

        // CAM write, stage 0, addr 3
        din_a  = {256{4'hA}};
        mask_f = '1;
        exp_q.push_back({1'b1, 4'h3});
        send_cam(12'h013, din_a, mask_f, 0);
        check("cam_strobe_now", 256'(lookup_din_en), 256'd1);
        check("cam_tready_bubble", 256'(s_axis_tready), 256'd0);
        idle(2);
        check_wide("cam_din", lookup_din, din_a);
        check_wide("cam_mask", lookup_din_mask, mask_f);
        check("cam_addr", 256'(lookup_din_addr), 256'h3);
        check("cam_wr_cnt", 256'(cfg_wr_cnt), 256'd1);

        // ACTION write, addr F, top beat all ones
        act1 = {256'h0, {64{4'h2}}, {64{4'h1}}};
        act1[767:512] = '1;
        exp_q.push_back({1'b0, 4'hF});
        send_act(12'h02F, act1);
        idle(2);
        check_wide("act_data", {399'd0, action_data_in}, {399'd0, 113'h1ffff_ffffffff_ffffffff_ffffffff, act1[511:0]});
        check("act_addr", 256'(action_addr), 256'hF);
        check_wide("act_cam_untouched", lookup_din, din_a);
        check("act_wr_cnt", 256'(cfg_wr_cnt), 256'd2);

        // Stage mismatch: consumed silently, never stalls
        stalls = 0;
        send_cam(12'h513, {256{4'h7}}, '0, 0);
        idle(2);
        check("mis_stalls", 256'(stalls), 256'd0);
        check("mis_err", 256'(err_pulses), 256'd0);
        check_wide("mis_din", lookup_din, din_a);
        check("mis_wr_cnt", 256'(cfg_wr_cnt), 256'd2);

        // Next message after mismatch writes normally
        act2 = {{64{4'h3}}, {64{4'hC}}, {64{4'h5}}};
        exp_q.push_back({1'b0, 4'h1});
        send_act(12'h021, act2);
        idle(2);
        check_wide("act2_data", {399'd0, action_data_in}, {399'd0, act2[624:0]});
        check("act2_addr", 256'(action_addr), 256'h1);

        // Unknown type, single-beat header: ignored, no error
        send_beat(256'h033, 1'b1, 0);
        idle(2);
        check("unk_err", 256'(err_pulses), 256'd0);

        // Early tlast in CAM payload
        send_beat(256'h017, 1'b0, 0);
        for (int k = 0; k < 5; k++) send_beat({64{4'h9}}, k == 4, 0);
        idle(2);
        check("early_err", 256'(err_pulses), 256'd1);
        check_wide("early_din", lookup_din, din_a);
        check("early_addr", 256'(lookup_din_addr), 256'h3);
        check("early_wr_cnt", 256'(cfg_wr_cnt), 256'd3);

        // Missing tlast in ACTION payload
        send_beat(256'h024, 1'b0, 0);
        for (int k = 0; k < 3; k++) send_beat({64{4'h6}}, 1'b0, 0);
        check("missing_err_after_beat3", 256'(cfg_err), 256'd1);
        send_beat({64{4'h6}}, 1'b0, 0);
        send_beat({64{4'h6}}, 1'b1, 0);
        idle(2);
        check("missing_err_total", 256'(err_pulses), 256'd2);
        check_wide("missing_act", {399'd0, action_data_in}, {399'd0, act2[624:0]});
        check("missing_wr_cnt", 256'(cfg_wr_cnt), 256'd3);

        // Reset in the middle of a CAM payload
        send_beat(256'h015, 1'b0, 0);
        for (int k = 0; k < 4; k++) send_beat({64{4'h5}}, 1'b0, 0);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_tready", 256'(s_axis_tready), 256'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle(2);
        check_wide("midrst_din", lookup_din, '0);
        check_wide("midrst_mask", lookup_din_mask, '0);
        check("midrst_act", 256'(action_data_in[255:0]), 256'd0);
        check("midrst_addrs", 256'({lookup_din_addr, action_addr}), 256'd0);
        check("midrst_wr_cnt", 256'(cfg_wr_cnt), 256'd0);

        // Gapless CAM message, then the same message with random tvalid gaps
        for (int k = 0; k < 4; k++) begin
            beat_tmp = {8{32'h1000_0000 + k}};
            din_g[k*256 +: 256] = beat_tmp;
            beat_tmp = {8{32'hC000_0000 + k}};
            mask_g[k*256 +: 256] = beat_tmp;
        end
        exp_q.push_back({1'b1, 4'hC});
        send_cam(12'h01C, din_g, mask_g, 0);
        idle(2);
        check_wide("gapless_din", lookup_din, din_g);
        check_wide("gapless_mask", lookup_din_mask, mask_g);
        check("gapless_wr_cnt", 256'(cfg_wr_cnt), 256'd1);
        exp_q.push_back({1'b1, 4'hC});
        send_cam(12'h01C, din_g, mask_g, 3);
        idle(2);
        check_wide("gapped_din", lookup_din, din_g);
        check_wide("gapped_mask", lookup_din_mask, mask_g);
        check("gapped_addr", 256'(lookup_din_addr), 256'hC);
        check("gapped_wr_cnt", 256'(cfg_wr_cnt), 256'd2);

        // final report
        idle(3);
        check("bubble_during_strobe", 256'(bubble_bad), 256'd0);
        check("exp_q_drained", 256'(exp_q.size()), 256'd0);
        check("err_pulses_final", 256'(err_pulses), 256'd2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        n_fail++;
        $display("FAIL global_timeout: got timeout expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lookup_cfg_writer.md
# lookup_cfg_writer

Control-plane front end for one match-action stage. It accepts table-configuration messages on a 256-bit AXI-Stream slave and decodes them into single-cycle write strobes on the stage's two control channels: the 1024-bit CAM entry port (data + mask) and the 625-bit action-RAM port. It sits between the configuration stream and `lookup_engine`, whose control-channel inputs it drives. Messages addressed to other stages are consumed and discarded.

## Interface
- `STAGE`, 0: stage ID this instance accepts (4-bit compare).
- `ACT_LEN`, 25: action slot width; action word is ACT_LEN*25 = 625 bits.
- `C_S_AXIS_DATA_WIDTH`, 256: stream width; fixed at 256.
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `s_axis_tdata` in 256: config beat.
- `s_axis_tvalid` in 1: beat valid.
- `s_axis_tlast` in 1: last beat of message.
- `s_axis_tready` out 1: beat accepted when tvalid && tready.
- `lookup_din` out 1024: CAM entry data.
- `lookup_din_mask` out 1024: CAM entry mask.
- `lookup_din_addr` out 4: CAM entry index.
- `lookup_din_en` out 1: CAM write strobe, 1 cycle.
- `action_data_in` out 625: action word.
- `action_addr` out 4: action-RAM index.
- `action_en` out 1: action-RAM write strobe, 1 cycle.
- `cfg_err` out 1: 1-cycle pulse on malformed message.
- `cfg_wr_cnt` out 16: completed writes, wraps at 0xFFFF->0.

## Operation
- Header beat (first beat of every message): [3:0] addr, [7:4] type (0x1 = CAM, 0x2 = ACTION, other = unknown), [11:8] stage, [255:12] ignored.
- CAM message: header + exactly 8 payload beats; beats 0-3 fill `lookup_din` (beat k -> bits [256k+255:256k]), beats 4-7 fill `lookup_din_mask` likewise.
- ACTION message: header + exactly 3 payload beats assembled as 768 bits, beat k -> [256k+255:256k]; `action_data_in` = bits [624:0], rest dropped.
- FSM states: IDLE, CAM_PAY, ACT_PAY, DROP, WRITE.
- IDLE: on accepted header: stage==STAGE and type CAM -> CAM_PAY; type ACTION -> ACT_PAY; latch addr; clear 3-bit beat counter. Stage mismatch or unknown type -> DROP (no error); if header tlast=1 in that case, stay IDLE. Matching known header with tlast=1 -> cfg_err, stay IDLE.
- CAM_PAY/ACT_PAY: each accepted beat stored at counter slot, counter++. tlast before final beat -> cfg_err, IDLE, no write. Final beat (7 for CAM, 2 for ACTION) with tlast=1 -> WRITE; without tlast -> cfg_err, DROP.
- DROP: consume beats until accepted tlast, then IDLE.
- WRITE: assert `lookup_din_en` (CAM) or `action_en` (ACTION) for exactly this cycle, increment cfg_wr_cnt, -> IDLE.
- Data/addr outputs are registered, update only while assembling their own message type, and hold between messages; they are stable during the strobe cycle. CAM and action outputs never change for a message of the other type.
- Partial payload of an aborted message is never written; the next valid message fully overwrites assembly slots.

## Timing
- Reset (rst sampled high at clk edge): state IDLE, counter 0, all data/addr outputs 0, `lookup_din_en`=`action_en`=`cfg_err`=0, `cfg_wr_cnt`=0.
- `s_axis_tready` = (state != WRITE) && !rst, combinational from state; 0 throughout reset.
- Write strobe asserts the cycle after the final payload beat is accepted; one bubble (tready=0) in that cycle.
- Throughput: CAM message 10 cycles min, ACTION 5 cycles min, back-to-back headers accepted the cycle after WRITE.
- tvalid gaps stall assembly without state change.
- `cfg_err` pulses the cycle after the offending beat is accepted.
- rst mid-message: message discarded, no strobe; remaining beats of that message arrive in IDLE and are parsed as a header (sender must also reset).

## Test plan
- CAM write STAGE=0: header 0x013 (stage 0, CAM, addr 3) + 8 beats of 0xA..A / mask 0xF..F, tlast on beat 8 -> one-cycle `lookup_din_en`, addr 3, din all 0xA, mask all 1, cfg_wr_cnt=1.
- ACTION write: header 0x02F + 3 beats with beat 2 = all-ones -> `action_en` one cycle, addr 0xF, action_data_in[624:512]=all 1s, [511:0]=earlier beats.
- Stage mismatch: header 0x513 at STAGE=0 + 8 beats -> no strobe, no cfg_err, tready high throughout, next message writes normally.
- Early tlast: CAM header + 5 beats with tlast on 5th -> cfg_err pulse, no strobe, lookup_din unchanged.
- Missing tlast: ACTION header + 5 beats, tlast on 5th -> cfg_err after beat 3, no strobe, beats 4-5 dropped, IDLE after.
- Reset mid-CAM payload after 4 beats -> outputs zero, no strobe; tvalid gaps inserted randomly in a full message -> identical result to gapless case.
